// File: rtl/ws2812_stream_decoder_pkg.sv
// ============================================================================
// Module : ws2812_stream_decoder_pkg
// Brief  : Shared WS2812 decoder types, pixel width and 40 MHz timing defaults.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ws2812_stream_decoder_pkg;

    localparam int PIXEL_W  = 24;
    localparam int BITCNT_W = 5;

    // Pulse-width defaults at a 40 MHz sampling clock
    localparam int DEF_BIT_THRESH   = 22;
    localparam int DEF_MIN_HIGH     = 4;
    localparam int DEF_MAX_HIGH     = 60;
    localparam int DEF_LATCH_CYCLES = 2000;
    localparam int DEF_MAX_LEDS     = 8;
    localparam int DEF_IDX_W        = 3;
    localparam int DEF_CNT_W        = 12;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/ws2812_pixel_ram.sv
// ============================================================================
// Module : ws2812_pixel_ram
// Brief  : Per-frame pixel capture array, present only with WS2812_DECODER_CAPTURE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef WS2812_DECODER_CAPTURE_EN
module ws2812_pixel_ram #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Deliberately unreset: contents survive reset so a frame can be inspected afterwards
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule
`endif

`default_nettype wire

// File: rtl/ws2812_stream_decoder.sv
// ============================================================================
// Module : ws2812_stream_decoder
// Brief  : Recovers GRB pixels and latch boundaries from a WS2812 pulse stream.
//          Optional capture array enabled by WS2812_DECODER_CAPTURE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ws2812_stream_decoder
    import ws2812_stream_decoder_pkg::*;
#(
    parameter int BIT_THRESH   = DEF_BIT_THRESH,
    parameter int MIN_HIGH     = DEF_MIN_HIGH,
    parameter int MAX_HIGH     = DEF_MAX_HIGH,
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
    parameter int MAX_LEDS     = DEF_MAX_LEDS,
    parameter int IDX_W        = DEF_IDX_W,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    output logic [PIXEL_W-1:0] pixel_data,
    output logic               pixel_valid,
    output logic [IDX_W-1:0]   pixel_index,
    output logic               frame_done,
    output logic [IDX_W:0]     frame_len,
    output logic               overflow,
    output logic               error
`ifdef WS2812_DECODER_CAPTURE_EN
    ,
    input  logic [IDX_W-1:0]   rd_addr,
    output logic [PIXEL_W-1:0] rd_data
`endif
);

    localparam int PC_W = IDX_W + 1;

    logic               sync1_q, sync2_q, prev_q;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0]   low_cnt_q, low_cnt_d;
    logic [PIXEL_W-1:0] shift_q, shift_d;
    logic [BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [PC_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic               pend_q, pend_d;
    logic [PIXEL_W-1:0] pixel_data_q, pixel_data_d;
    logic               pixel_valid_q, pixel_valid_d;
    logic [IDX_W-1:0]   pixel_index_q, pixel_index_d;
    logic               frame_done_q, frame_done_d;
    logic [PC_W-1:0]    frame_len_q, frame_len_d;
    logic               overflow_q, overflow_d;
    logic               error_q, error_d;

    logic               w_rise, w_fall, w_bit;
    logic [CNT_W-1:0]   w_high_inc, w_low_inc;

    assign w_rise     = sync2_q & ~prev_q;
    assign w_fall     = ~sync2_q & prev_q;
    assign w_bit      = (high_cnt_q >= CNT_W'(BIT_THRESH));
    assign w_high_inc = (&high_cnt_q) ? high_cnt_q : high_cnt_q + 1'b1;
    assign w_low_inc  = (&low_cnt_q)  ? low_cnt_q  : low_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            prev_q        <= 1'b0;
            state_q       <= ST_SYNC;
            high_cnt_q    <= '0;
            low_cnt_q     <= '0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            pix_cnt_q     <= '0;
            pend_q        <= 1'b0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
            pixel_index_q <= '0;
            frame_done_q  <= 1'b0;
            frame_len_q   <= '0;
            overflow_q    <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            sync1_q       <= din;
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
            state_q       <= state_d;
            high_cnt_q    <= high_cnt_d;
            low_cnt_q     <= low_cnt_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            pend_q        <= pend_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_index_q <= pixel_index_d;
            frame_done_q  <= frame_done_d;
            frame_len_q   <= frame_len_d;
            overflow_q    <= overflow_d;
            error_q       <= error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        high_cnt_d    = high_cnt_q;
        low_cnt_d     = low_cnt_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        pend_d        = 1'b0;
        pixel_data_d  = pixel_data_q;
        pixel_valid_d = 1'b0;
        pixel_index_d = pixel_index_q;
        frame_done_d  = 1'b0;
        frame_len_d   = frame_len_q;
        overflow_d    = overflow_q;
        error_d       = 1'b0;

        // Publish a completed word the cycle after its 24th bit was shifted in
        if (pend_q) begin
            if (pix_cnt_q == PC_W'(MAX_LEDS)) begin
                overflow_d = 1'b1;
            end else begin
                pixel_data_d  = shift_q;
                pixel_valid_d = 1'b1;
                pixel_index_d = pix_cnt_q[IDX_W-1:0];
                pix_cnt_d     = pix_cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_SYNC: begin
                if (sync2_q) begin
                    low_cnt_d = '0;
                end else if (w_low_inc == CNT_W'(LATCH_CYCLES)) begin
                    low_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    low_cnt_d = w_low_inc;
                end
            end
            ST_IDLE: begin
                if (w_rise) begin
                    high_cnt_d = CNT_W'(1);
                    state_d    = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (w_fall) begin
                    low_cnt_d = CNT_W'(1);
                    state_d   = ST_LOW;
                    if (high_cnt_q < CNT_W'(MIN_HIGH)) begin
                        error_d = 1'b1;
                    end else begin
                        shift_d = {shift_q[PIXEL_W-2:0], w_bit};
                        if (bit_cnt_q == BITCNT_W'(PIXEL_W - 1)) begin
                            bit_cnt_d = '0;
                            pend_d    = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end else if (high_cnt_q >= CNT_W'(MAX_HIGH)) begin
                    // Stuck-high line: drop the partial word and resynchronise
                    error_d   = 1'b1;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    low_cnt_d = '0;
                    state_d   = ST_SYNC;
                end else begin
                    high_cnt_d = w_high_inc;
                end
            end
            ST_LOW: begin
                if (w_rise) begin
                    high_cnt_d = CNT_W'(1);
                    state_d    = ST_HIGH;
                end else if (w_low_inc == CNT_W'(LATCH_CYCLES)) begin
                    frame_done_d = 1'b1;
                    frame_len_d  = pix_cnt_q;
                    pix_cnt_d    = '0;
                    overflow_d   = 1'b0;
                    low_cnt_d    = '0;
                    state_d      = ST_IDLE;
                    if (bit_cnt_q != '0) begin
                        error_d   = 1'b1;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end
                end else begin
                    low_cnt_d = w_low_inc;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    assign pixel_data  = pixel_data_q;
    assign pixel_valid = pixel_valid_q;
    assign pixel_index = pixel_index_q;
    assign frame_done  = frame_done_q;
    assign frame_len   = frame_len_q;
    assign overflow    = overflow_q;
    assign error       = error_q;

`ifdef WS2812_DECODER_CAPTURE_EN
    ws2812_pixel_ram #(
        .DEPTH  (MAX_LEDS),
        .ADDR_W (IDX_W),
        .DATA_W (PIXEL_W)
    ) u_pixel_ram (
        .clk     (clk),
        .we_i    (pixel_valid_q),
        .waddr_i (pixel_index_q),
        .wdata_i (pixel_data_q),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_ws2812_stream_decoder.sv
// ============================================================================
// Module : tb_ws2812_stream_decoder
// Brief  : Self-checking bench: table frames, random frames, timing corner cases.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ws2812_stream_decoder;

    localparam int IDX_W    = 3;
    localparam int MAX_LEDS = 8;
    localparam int LATCH    = 2000;
    localparam int T1H      = 28;
    localparam int T0H      = 14;
    localparam int TBIT     = 50;

    logic              clk = 1'b0;
    logic              reset;
    logic              din;
    logic [23:0]       pixel_data;
    logic              pixel_valid;
    logic [IDX_W-1:0]  pixel_index;
    logic              frame_done;
    logic [IDX_W:0]    frame_len;
    logic              overflow;
    logic              error;
`ifdef WS2812_DECODER_CAPTURE_EN
    logic [IDX_W-1:0]  rd_addr;
    logic [23:0]       rd_data;
`endif

    ws2812_stream_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_index (pixel_index),
        .frame_done  (frame_done),
        .frame_len   (frame_len),
        .overflow    (overflow),
        .error       (error)
`ifdef WS2812_DECODER_CAPTURE_EN
        ,
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Observations gathered by the monitor since the last clear
    logic [23:0] obs_px  [$];
    int          obs_idx [$];
    int          obs_len [$];
    int          obs_err;
    int          err_with_done;
    int          ovf_first;
    int          ovf_after;
    int          strobe_in_rst;
    logic        fd_prev  = 1'b0;
    logic        rst_prev = 1'b0;

    logic [23:0] tx_q [$];

    typedef struct {
        string       name;
        int          npix;
        logic [9:0][23:0] px;
        int          exp_len;
    } vec_t;
    vec_t vecs [4];

    always @(negedge clk) begin
        if (pixel_valid) begin
            obs_px.push_back(pixel_data);
            obs_idx.push_back(int'(pixel_index));
        end
        if (frame_done) obs_len.push_back(int'(frame_len));
        if (error) obs_err++;
        if (error && frame_done) err_with_done++;
        if (overflow && ovf_first < 0) ovf_first = obs_px.size();
        if (fd_prev) ovf_after = int'(overflow);
        if ((reset || rst_prev) && (pixel_valid || frame_done || error)) strobe_in_rst++;
        fd_prev  = frame_done;
        rst_prev = reset;
    end

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic clear_obs();
        obs_px.delete();
        obs_idx.delete();
        obs_len.delete();
        obs_err       = 0;
        err_with_done = 0;
        ovf_first     = -1;
        ovf_after     = -1;
    endtask

    // Called right after a rising clock edge; holds din for n cycles
    task automatic drive(input logic v, input int n);
        #1 din = v;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_pixel(input logic [23:0] w, input int glitch_after, input int nbits);
        logic [23:0] word;
        logic        b;
        word = w;
        for (int i = 0; i < nbits; i++) begin
            b = word[23-i];
            drive(1'b1, b ? T1H : T0H);
            drive(1'b0, b ? TBIT - T1H : TBIT - T0H);
            if (i == glitch_after) begin
                drive(1'b1, 2);
                drive(1'b0, 10);
            end
        end
    endtask

    task automatic send_frame(input int glitch_after);
        foreach (tx_q[i]) send_pixel(tx_q[i], glitch_after, 24);
        drive(1'b0, LATCH + 20);
    endtask

    // Reference: first MAX_LEDS pixels appear in order at indices 0..,
    // overflow rises only after MAX_LEDS strobes, one latch per frame.
    task automatic check_frame(input string name, input int exp_err, input int exp_len);
        int n_exp;
        n_exp = (tx_q.size() > MAX_LEDS) ? MAX_LEDS : tx_q.size();
        check({name, " pixel_valid count"}, obs_px.size(), n_exp);
        for (int i = 0; i < n_exp && i < obs_px.size(); i++) begin
            check($sformatf("%s pixel_data[%0d]", name, i), int'(obs_px[i]), int'(tx_q[i]));
            check($sformatf("%s pixel_index[%0d]", name, i), obs_idx[i], i);
        end
        check({name, " frame_done count"}, obs_len.size(), 1);
        if (obs_len.size() > 0) check({name, " frame_len"}, obs_len[0], exp_len);
        check({name, " error count"}, obs_err, exp_err);
        check({name, " overflow onset"}, ovf_first, (tx_q.size() > MAX_LEDS) ? MAX_LEDS : -1);
        check({name, " overflow after frame_done"}, ovf_after, 0);
    endtask

    initial begin
        int n;

        vecs[0].name = "single";  vecs[0].npix = 1;  vecs[0].exp_len = 1;
        vecs[0].px = '0;          vecs[0].px[0] = 24'hFF00A5;
        vecs[1].name = "three";   vecs[1].npix = 3;  vecs[1].exp_len = 3;
        vecs[1].px = '0;
        vecs[1].px[0] = 24'h000001; vecs[1].px[1] = 24'h800000; vecs[1].px[2] = 24'h123456;
        vecs[2].name = "ten";     vecs[2].npix = 10; vecs[2].exp_len = 8;
        for (int i = 0; i < 10; i++) vecs[2].px[i] = 24'h0F0F00 ^ (24'(i) * 24'h010203);
        vecs[3].name = "extremes"; vecs[3].npix = 2; vecs[3].exp_len = 2;
        vecs[3].px = '0;          vecs[3].px[0] = 24'hFFFFFF;

        reset = 1'b1;
        din   = 1'b0;
`ifdef WS2812_DECODER_CAPTURE_EN
        rd_addr = '0;
`endif
        clear_obs();
        strobe_in_rst = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset pixel_data", int'(pixel_data), 0);
        check("reset pixel_valid", int'(pixel_valid), 0);
        check("reset pixel_index", int'(pixel_index), 0);
        check("reset frame_done", int'(frame_done), 0);
        check("reset frame_len", int'(frame_len), 0);
        check("reset overflow", int'(overflow), 0);
        check("reset error", int'(error), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(1'b0, LATCH + 20);
        check("sync no frame_done", obs_len.size(), 0);

        for (int v = 0; v < 4; v++) begin
            clear_obs();
            tx_q.delete();
            for (int i = 0; i < vecs[v].npix; i++) tx_q.push_back(vecs[v].px[i]);
            send_frame(-1);
            check_frame(vecs[v].name, 0, vecs[v].exp_len);
        end

        for (int f = 0; f < 3; f++) begin
            clear_obs();
            tx_q.delete();
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) tx_q.push_back(24'($urandom()));
            send_frame(-1);
            check_frame($sformatf("random%0d", f), 0, n);
        end

        // Short high pulse between bits: flagged, word unaffected
        clear_obs();
        tx_q.delete();
        tx_q.push_back(24'hA5C3F0);
        send_frame(10);
        check_frame("glitch", 1, 1);

        // Over-long high forces resync; pixels before the next latch are ignored
        clear_obs();
        drive(1'b1, 70);
        drive(1'b0, 100);
        check("longhigh error", obs_err, 1);
        send_pixel(24'h00FF00, -1, 24);
        drive(1'b0, LATCH + 20);
        check("longhigh no pixel in sync", obs_px.size(), 0);
        check("longhigh no frame_done in sync", obs_len.size(), 0);
        tx_q.delete();
        tx_q.push_back(24'h00FF00);
        send_frame(-1);
        check_frame("after longhigh", 1, 1);

        // Partial word at latch
        clear_obs();
        send_pixel(24'hFFF000, -1, 12);
        drive(1'b0, LATCH + 20);
        check("partial pixel_valid count", obs_px.size(), 0);
        check("partial frame_done count", obs_len.size(), 1);
        if (obs_len.size() > 0) check("partial frame_len", obs_len[0], 0);
        check("partial error with frame_done", err_with_done, 1);
        check("partial error count", obs_err, 1);

        // Reset in the middle of a frame's second pixel
        clear_obs();
        send_pixel(24'h13579B, -1, 24);
        send_pixel(24'hFFFFFF, -1, 10);
        drive(1'b1, 10);
        #1 reset = 1'b1;
        din = 1'b0;
        strobe_in_rst = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        check("reset strobes", strobe_in_rst, 0);
        drive(1'b0, LATCH + 20);
        clear_obs();
        tx_q.delete();
        tx_q.push_back(24'h5A5A5A);
        tx_q.push_back(24'hC0FFEE);
        send_frame(-1);
        check_frame("after reset", 0, 2);

`ifdef WS2812_DECODER_CAPTURE_EN
        clear_obs();
        tx_q.delete();
        for (int i = 0; i < 4; i++) tx_q.push_back(24'($urandom()));
        send_frame(-1);
        check_frame("capture", 0, 4);
        for (int a = 0; a < 4; a++) begin
            #1 rd_addr = IDX_W'(a);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("rd_data[%0d]", a), int'(rd_data), int'(tx_q[a]));
            @(posedge clk);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
